// File: rtl/pads_cnfg_loader.sv
// pads_cnfg_loader: byte-stream loader for the pad-ring configuration.
// Bytes are assembled little-endian into shadow cnfg_io/cnfg_en vectors. A
// complete frame is committed atomically to the registered outputs.
// Optional build macro PADS_CNFG_CHKSUM_EN appends an XOR checksum byte to
// each frame. When the checksum does not match, the frame is discarded and
// frm_err pulses. Without the macro, frm_err is tied low.
module pads_cnfg_loader #(
    parameter int unsigned NPADS  = 44,
    parameter int unsigned NBYTES = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frm_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [NPADS-1:0] cnfg_io,
    output logic [NPADS-1:0] cnfg_en,
    output logic             cnfg_upd,
    output logic             busy,
    output logic             frm_err
);

`ifdef PADS_CNFG_CHKSUM_EN
    localparam int unsigned FRAME_LEN = 2 * NBYTES + 1;
`else
    localparam int unsigned FRAME_LEN = 2 * NBYTES;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NPADS-1:0]  sh_io_q, sh_io_d;
    logic [NPADS-1:0]  sh_en_q, sh_en_d;
    logic [NPADS-1:0]  io_q, io_d;
    logic [NPADS-1:0]  en_q, en_d;
    logic              upd_q, upd_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic              accept;
    logic              commit_ok;
    logic [3:0]        idx;

    assign accept = in_valid && rdy_q;

    // State, counter, shadow and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_io_q <= '0;
            sh_en_q <= '0;
            io_q    <= '0;
            en_q    <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_io_q <= sh_io_d;
            sh_en_q <= sh_en_d;
            io_q    <= io_d;
            en_q    <= en_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic: byte placement, frame sequencing and commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_io_d = sh_io_q;
        sh_en_d = sh_en_q;
        io_d    = io_q;
        en_d    = en_q;
        upd_d   = 1'b0;
        // A restart pulse makes the byte in the same cycle byte 0.
        idx     = frm_start ? 4'd0 : cnt_q;
        unique case (state_q)
            IDLE, LOAD: begin
                if (frm_start) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                if (accept) begin
                    for (int unsigned b = 0; b < NPADS; b++) begin
                        if (b / 8 == 32'(idx))
                            sh_io_d[b] = in_data[3'(b % 8)];
                        if (b / 8 + NBYTES == 32'(idx))
                            sh_en_d[b] = in_data[3'(b % 8)];
                    end
                    if (idx == LAST_IDX) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = idx + 4'd1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (commit_ok) begin
                    io_d  = sh_io_q;
                    en_d  = sh_en_q;
                    upd_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake and status are registered, so derive them from next state.
        rdy_d  = (state_d != COMMIT);
        busy_d = (cnt_d != 4'd0) || (state_d == COMMIT);
    end

`ifdef PADS_CNFG_CHKSUM_EN
    logic [7:0] chk_q;
    logic       err_q;

    // Running XOR over the frame; it is zero after a correct checksum byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            chk_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept)
                chk_q <= (idx == 4'd0) ? in_data : (chk_q ^ in_data);
            err_q <= (state_q == COMMIT) && (chk_q != 8'h00);
        end
    end

    assign commit_ok = (chk_q == 8'h00);
    assign frm_err   = err_q;
`else
    assign commit_ok = 1'b1;
    assign frm_err   = 1'b0;
`endif

    assign in_ready = rdy_q;
    assign busy     = busy_q;
    assign cnfg_io  = io_q;
    assign cnfg_en  = en_q;
    assign cnfg_upd = upd_q;

endmodule

// File: tb/tb_pads_cnfg_loader.sv
// Testbench for pads_cnfg_loader: a randomized byte-stream driver feeds a
// frame-level reference model. A scoreboard queue holds the expected commits,
// and a monitor compares the outputs every cycle.
module tb_pads_cnfg_loader;
    localparam int unsigned NPADS  = 44;
    localparam int unsigned NBYTES = 6;
`ifdef PADS_CNFG_CHKSUM_EN
    localparam int unsigned FLEN = 2 * NBYTES + 1;
`else
    localparam int unsigned FLEN = 2 * NBYTES;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             frm_start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic [NPADS-1:0] cnfg_io;
    logic [NPADS-1:0] cnfg_en;
    logic             cnfg_upd;
    logic             busy;
    logic             frm_err;

    pads_cnfg_loader #(.NPADS(NPADS), .NBYTES(NBYTES)) dut (
        .clock     (clock),
        .reset     (reset),
        .frm_start (frm_start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cnfg_io   (cnfg_io),
        .cnfg_en   (cnfg_en),
        .cnfg_upd  (cnfg_upd),
        .busy      (busy),
        .frm_err   (frm_err)
    );

    typedef struct {
        bit               err;
        logic [NPADS-1:0] io;
        logic [NPADS-1:0] en;
        int unsigned      cyc;
    } exp_t;

    exp_t             sb[$];
    logic [7:0]       cur[$];
    logic [NPADS-1:0] mio = '0;
    logic [NPADS-1:0] men = '0;
    int unsigned      cyc = 0;
    int               tests = 0;
    int               fails = 0;
    bit               mon_en = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Little-endian assembly of NBYTES bytes starting at base, truncated to NPADS.
    function automatic logic [NPADS-1:0] vec_of(input logic [7:0] f[$], input int unsigned base);
        logic [63:0] acc = '0;
        for (int unsigned k = 0; k < NBYTES; k++)
            acc = acc + (64'(f[base + k]) << (8 * k));
        return acc[NPADS-1:0];
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit fs, input int unsigned gap_pct);
        int unsigned c;
        int unsigned guard;
        exp_t        e;
        logic [7:0]  x;
        while ($urandom_range(99, 0) < gap_pct) begin
            @(negedge clock);
            in_valid  = 1'b0;
            frm_start = 1'b0;
            in_data   = 8'($urandom);
        end
        guard = 0;
        forever begin
            @(negedge clock);
            in_valid  = 1'b1;
            in_data   = d;
            frm_start = fs;
            #1;
            if (in_ready) break;
            guard++;
            if (guard > 20) begin
                check("handshake_timeout", 64'(in_ready), 64'd1);
                in_valid  = 1'b0;
                frm_start = 1'b0;
                return;
            end
        end
        c = cyc;
        @(posedge clock);
        if (fs) cur.delete();
        cur.push_back(d);
        if (cur.size() == FLEN) begin
            e.err = 1'b0;
            e.io  = vec_of(cur, 0);
            e.en  = vec_of(cur, NBYTES);
            e.cyc = c + 2;
`ifdef PADS_CNFG_CHKSUM_EN
            x = 8'h00;
            for (int unsigned k = 0; k < 2 * NBYTES; k++) x = x ^ cur[k];
            e.err = (x != cur[2 * NBYTES]);
`else
            x = 8'h00;
`endif
            sb.push_back(e);
            cur.delete();
        end
        #1;
        in_valid  = 1'b0;
        frm_start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit fs_first,
                              input int unsigned gap, input logic [7:0] flip);
        logic [7:0] x = 8'h00;
        foreach (f[i]) begin
            send_byte(f[i], (i == 0) && fs_first, gap);
            x = x ^ f[i];
        end
`ifdef PADS_CNFG_CHKSUM_EN
        send_byte(x ^ flip, 1'b0, gap);
`else
        x = x ^ flip;
`endif
    endtask

    function automatic void rand_frame(output logic [7:0] f[$]);
        f.delete();
        for (int i = 0; i < 2 * NBYTES; i++) f.push_back(8'($urandom));
    endfunction

    task automatic do_reset(input int unsigned n);
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        frm_start = 1'b0;
        cur.delete();
        sb.delete();
        mio = '0;
        men = '0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clock);
        #3;
    endtask

    // Monitor: compare every cycle against the scoreboard and the committed model.
    initial begin
        exp_t e;
        bit   pend;
        forever begin
            @(negedge clock);
            #2;
            if (reset || !mon_en) continue;
            pend = 1'b0;
            foreach (sb[i]) if (sb[i].cyc == cyc + 1) pend = 1'b1;
            check("in_ready", 64'(in_ready), 64'(!pend));
            check("busy", 64'(busy), 64'((cur.size() != 0) || pend));
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("cnfg_upd_commit", 64'(cnfg_upd), 64'(!e.err));
                check("frm_err_commit", 64'(frm_err), 64'(e.err));
                if (!e.err) begin
                    mio = e.io;
                    men = e.en;
                end
                check("cnfg_io_commit", 64'(cnfg_io), 64'(mio));
                check("cnfg_en_commit", 64'(cnfg_en), 64'(men));
            end else begin
                check("cnfg_upd_quiet", 64'(cnfg_upd), 64'd0);
                check("frm_err_quiet", 64'(frm_err), 64'd0);
                check("cnfg_io_hold", 64'(cnfg_io), 64'(mio));
                check("cnfg_en_hold", 64'(cnfg_en), 64'(men));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [7:0] f[$];
        logic [7:0] g[$];

        do_reset(2);
        mon_en = 1'b1;
        #3;
        check("reset_io", 64'(cnfg_io), 64'd0);
        check("reset_en", 64'(cnfg_en), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);

        // Directed frame with known result.
        f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF6,
              8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h0B};
        send_frame(f, 1'b0, 0, 8'h00);
        idle(4);
        check("full_io_value", 64'(cnfg_io), 64'h605_0403_0201);
        check("full_en_value", 64'(cnfg_en), 64'hBAA_AAAA_AAAA);

        // Abort after 7 bytes, restart with 0x11 in the same cycle as frm_start.
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0, 0);
        rand_frame(g);
        g[0] = 8'h11;
        send_frame(g, 1'b1, 0, 8'h00);
        idle(4);
        check("abort_io_byte0", 64'(cnfg_io[7:0]), 64'h11);

        // Random frames, back-to-back and with valid gaps.
        for (int i = 0; i < 6; i++) begin
            rand_frame(f);
            send_frame(f, 1'b0, (i % 2 == 1) ? 40 : 0, 8'h00);
        end

        // All-ones (ignored upper nibble) and repeated identical commits.
        f.delete();
        for (int i = 0; i < 2 * NBYTES; i++) f.push_back(8'hFF);
        send_frame(f, 1'b0, 0, 8'h00);
        send_frame(f, 1'b0, 0, 8'h00);
        idle(4);
        check("ones_io_value", 64'(cnfg_io), 64'hFFF_FFFF_FFFF);

        // Reset in the middle of a frame.
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b0, 20);
        do_reset(1);
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_io", 64'(cnfg_io), 64'd0);
        check("midreset_en", 64'(cnfg_en), 64'd0);
        rand_frame(f);
        send_frame(f, 1'b0, 30, 8'h00);

`ifdef PADS_CNFG_CHKSUM_EN
        rand_frame(f);
        send_frame(f, 1'b0, 0, 8'h00);
        rand_frame(f);
        send_frame(f, 1'b0, 0, 8'h04);
        rand_frame(f);
        send_frame(f, 1'b0, 20, 8'h80);
        rand_frame(f);
        send_frame(f, 1'b0, 0, 8'h00);
`endif

        idle(20);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
